// File: rtl/lane_mux_serializer.sv
`default_nettype none
// ============================================================================
// Module   : lane_mux_serializer
// Purpose  : Registered lane multiplexer / serializer. Takes an N*M-bit word
//            over a valid/ready handshake and emits its N-bit lanes over a
//            registered valid/ready interface.
//              direct mode    (i_mode=0): one beat carrying lane i_sel
//              serialize mode (i_mode=1): M beats starting at lane i_sel
//                                         (0 if out of range), wrapping mod M
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk    in   1      clock, rising edge
//   i_rst_n  in   1      asynchronous active-low reset
//   i_data   in   N*M    input word, lane k = i_data[k*N +: N]
//   i_sel    in   SEL_W  direct lane / serialize start lane
//   i_mode   in   1      0 = direct, 1 = serialize
//   i_valid  in   1      upstream word valid
//   o_ready  out  1      upstream ready
//   o_data   out  N      output lane data
//   o_lane   out  SEL_W  lane index shown on o_data
//   o_valid  out  1      output beat valid
//   o_last   out  1      final beat of the current word
//   i_ready  in   1      downstream ready
//   o_busy   out  1      a word is held
// ============================================================================
module lane_mux_serializer #(
  parameter int N     = 8,
  parameter int M     = 8,
  parameter int SEL_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N*M-1:0]   i_data,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_mode,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [N-1:0]     o_data,
  output logic [SEL_W-1:0] o_lane,
  output logic             o_valid,
  output logic             o_last,
  input  logic             i_ready,
  output logic             o_busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [SEL_W:0]   c_M    = (SEL_W+1)'(M);
  localparam logic [SEL_W-1:0] c_LAST = SEL_W'(M-1);

  state_t             r_state, w_state_nxt;
  logic [N*M-1:0]     r_word,  w_word_nxt;
  logic [SEL_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [SEL_W-1:0]   r_lane,  w_lane_nxt;
  logic [N-1:0]       r_data,  w_data_nxt;
  logic               r_last,  w_last_nxt;

  logic               w_ready;
  logic               w_accept;
  logic               w_hs;
  logic [SEL_W-1:0]   w_start;
  logic [SEL_W-1:0]   w_first_lane;
  logic [SEL_W-1:0]   w_lane_inc;
  logic [SEL_W-1:0]   w_cnt_inc;

  // Lane extraction; indices at or beyond M yield zero, which covers an
  // out-of-range direct select.
  function automatic logic [N-1:0] f_lane(input logic [N*M-1:0] word,
                                          input logic [SEL_W-1:0] lane);
    f_lane = '0;
    for (int k = 0; k < M; k++) begin
      if (lane == SEL_W'(k)) f_lane = word[k*N +: N];
    end
  endfunction

  // A new word may be taken while idle, or in the same edge that retires
  // the final beat of the current word (no bubble between words).
  assign w_ready  = i_rst_n &&
                    ((r_state == ST_IDLE) || (r_last && i_ready));
  assign w_accept = i_valid && w_ready;
  assign w_hs     = (r_state == ST_SEND) && i_ready;

  // Serialize start lane is remapped to 0 when out of range; direct mode
  // keeps the raw select.
  assign w_start      = ({1'b0, i_sel} < c_M) ? i_sel : '0;
  assign w_first_lane = i_mode ? w_start : i_sel;
  assign w_lane_inc   = (r_lane == c_LAST) ? '0 : r_lane + 1'b1;
  assign w_cnt_inc    = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_cnt_nxt   = r_cnt;
    w_lane_nxt  = r_lane;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    if (w_accept) begin
      w_state_nxt = ST_SEND;
      w_word_nxt  = i_data;
      w_cnt_nxt   = '0;
      w_lane_nxt  = w_first_lane;
      w_data_nxt  = f_lane(i_data, w_first_lane);
      // M >= 2, so the first serialize beat is never the last one.
      w_last_nxt  = !i_mode;
    end else if (w_hs) begin
      if (r_last) begin
        w_state_nxt = ST_IDLE;
        w_last_nxt  = 1'b0;
      end else begin
        w_cnt_nxt  = w_cnt_inc;
        w_lane_nxt = w_lane_inc;
        w_data_nxt = f_lane(r_word, w_lane_inc);
        w_last_nxt = (w_cnt_inc == c_LAST);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_cnt   <= '0;
      r_lane  <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lane  <= w_lane_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign o_ready = w_ready;
  assign o_data  = r_data;
  assign o_lane  = r_lane;
  assign o_last  = r_last;
  assign o_valid = (r_state == ST_SEND);
  assign o_busy  = (r_state == ST_SEND);

endmodule
`default_nettype wire

// File: doc/lane_mux_serializer.md
Name: lane_mux_serializer

Overview:
- Parametrised, registered successor to the combinational N-bit-lane, M-lane word multiplexer.
- Accepts an N*M-bit word over a valid/ready handshake and outputs lanes through a registered valid/ready interface.
- Direct mode outputs one selected lane.
- Serialize mode outputs all M lanes in turn, starting at a selectable lane and wrapping modulo M.
- Sits between wide datapaths and byte-wide consumers such as UART or SPI transmitters.

Parameters:
- N, 8, lane width in bits.
- M, 8, lane count (2..2^SEL_W).
- SEL_W, 3, select/lane-index width; must satisfy 2^SEL_W >= M.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_data  in  N*M  input word; lane k = i_data[k*N +: N].
- i_sel  in  SEL_W  direct-mode lane / serialize-mode start lane.
- i_mode  in  1  0 = direct (single lane), 1 = serialize (M lanes).
- i_valid  in  1  upstream word valid.
- o_ready  out  1  upstream ready (combinational from state and i_ready).
- o_data  out  N  output lane data.
- o_lane  out  SEL_W  index of the lane on o_data.
- o_valid  out  1  output beat valid.
- o_last  out  1  final beat of the current word.
- i_ready  in  1  downstream ready.
- o_busy  out  1  high while a word is held (state SEND).

Behaviour:
- Reset (i_rst_n low), applied immediately and asynchronously:
  - state = IDLE.
  - o_data, o_lane, o_valid, o_last, o_busy = 0; word register and beat counter = 0.
  - o_ready = 0 while i_rst_n is low.
- States:
  - IDLE: o_ready = 1, o_valid = 0.
  - SEND: o_valid = 1, o_busy = 1.
- Accept: i_valid && o_ready at a rising edge.
  - Capture i_data (whole word), i_mode, and start lane s.
  - s = i_sel if i_sel < M, else s = 0.
  - Enter SEND; the first beat is valid in the cycle after the accept edge (1-cycle latency).
- Lane data: if o_lane < M, o_data = stored lane o_lane. A direct-mode i_sel >= M is not remapped; that beat has o_data = 0 and o_lane = i_sel.
- Direct mode: exactly one beat with o_lane = i_sel and o_last = 1.
- Serialize mode:
  - M beats; beat j carries lane (s + j) mod M.
  - Lane index wraps from M-1 to 0.
  - o_last = 1 on beat M-1 only.
- Beat handshake (o_valid && i_ready at an edge):
  - Not last beat: advance lane and beat counter.
  - Last beat: go to IDLE, or reload if a new word is accepted in the same cycle.
- Backpressure: while i_ready = 0, o_data, o_lane, o_last and o_valid hold stable. o_valid never drops before the handshake.
- Back-to-back:
  - o_ready = IDLE || (SEND && o_last && i_ready).
  - A word offered during the final handshake is accepted in the same edge.
  - Its first beat follows with no bubble.
- Mid-word input changes: i_mode, i_sel and i_data changes while in SEND are ignored; only values at the accept edge count.
- Reset mid-word: the word is discarded and no further beats are produced. After release, the block is in IDLE with o_ready = 1.
- No combinational path from i_valid to any output. The only combinational output path is i_ready to o_ready.

Test Plan:
Default N=8, M=8, i_data = 64'hABCD_EFAB_CDEF_ABCD, giving lanes 0..7 = CD, AB, EF, CD, AB, EF, CD, AB.

1. Direct sweep: i_mode=0, i_sel 0..7, i_ready=1 → one beat each.
   - o_data = CD, AB, EF, CD, AB, EF, CD, AB.
   - o_lane = i_sel, o_last = 1, first o_valid one cycle after accept.
2. Serialize with wrap: i_mode=1, i_sel=5, i_ready=1 → 8 consecutive beats.
   - o_lane = 5, 6, 7, 0, 1, 2, 3, 4.
   - o_data = EF, CD, AB, CD, AB, EF, CD, AB.
   - o_last only on lane 4; o_ready low from the accept edge until the final beat's handshake cycle.
3. Backpressure: serialize i_sel=0, i_ready low for 3 cycles at beat 2 → o_data = EF and o_lane = 2 held stable with o_valid = 1; the sequence resumes intact.
4. Back-to-back:
   - Second word 64'h0706_0504_0302_0100 is valid during the final handshake of word 1 → accepted that cycle.
   - The next cycle shows o_data = 00, o_lane = 0, with no idle cycle.
   - Also: i_mode toggled mid-word has no effect.
5. Out-of-range with M=6, SEL_W=3:
   - Direct i_sel = 6 → single beat o_data = 0, o_lane = 6, o_last = 1.
   - Serialize i_sel = 7 → 6 beats on lanes 0..5.
6. Reset mid-word: assert i_rst_n low after 3 serialize beats, mid-cycle.
   - o_valid, o_data, o_lane and o_busy go to 0 immediately; o_ready = 0 during reset.
   - After release: o_ready = 1, and a new word serializes from its own i_sel.
